adrv9009_hb_dec: RTL
====================

Name: adrv9009_hb_dec

Overview:
- Parametrised half-band FIR decimate-by-2 for the ADRV9009 Rx signal path. Processes one I/Q channel pair.
- Successor to the fixed 9-tap, non-decimating half-band stage. Adds configurable width, tap count and coefficients, a valid-qualified input, 2:1 decimation, symmetric pre-add, round-half-up output scaling, and synchronous flush.
- Sits between upstream Rx half-band/FIR stages and the JESD/output formatter.

Parameters:
- DATA_W, 16: I/Q sample width, two's complement.
- COEF_W, 16: coefficient width, signed Q1.(COEF_W-1).
- NTAPS, 11: total taps. Must equal 4M-1 with M>=2; elaboration error otherwise.
- NSIDE, (NTAPS+1)/4: number of unique nonzero side coefficients. Derived; not overridable.
- SIDE_COEFS, {16'sd576, -16'sd2464, 16'sd10080}: packed NSIDE*COEF_W vector. Index 0 (LSB slice) is nearest the centre.
- CENTER_COEF, 16'sd16384: centre tap value (0.5).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- sync_clr  in  1  synchronous flush of delay line, phase and in-flight pipeline.
- in_valid  in  1  qualifies in_i/in_q for one cycle.
- in_i  in  DATA_W  I sample.
- in_q  in  DATA_W  Q sample.
- out_valid  out  1  one-cycle strobe, at most once per two accepted inputs.
- out_i  out  DATA_W  filtered, decimated I.
- out_q  out  DATA_W  filtered, decimated Q.

Behaviour:
- Reset (reset_n low, asynchronous):
  - delay lines, phase, pipeline valids, out_valid, out_i and out_q all go to 0.
  - Effective immediately, mid-operation included.
  - First in_valid after release is phase 0.
- Delay line:
  - NTAPS deep per channel; shifts only when in_valid=1.
  - No backpressure: the block accepts every in_valid.
- Phase bit:
  - Toggles on each accepted sample.
  - Accepting a phase-1 sample launches one computation over the window that includes it. Phase-0 samples launch nothing.
- Filter taps:
  - Taps at even distance 2..(NTAPS-1)/2-1 from the centre are structurally zero. Neither multiply nor store any coefficient for them.
  - Side taps are symmetric. Pre-add the mirrored pair: width DATA_W+1.
  - Products: DATA_W+COEF_W+1 bits.
  - Accumulator: ACC_W = DATA_W+COEF_W+1+clog2(NSIDE+1).
- Pipeline, in order: pre-add register, multiply register, clog2(NSIDE+1) adder-tree register stages (centre product enters the tree as one term), round/limit register.
  - LAT = 3+clog2(NSIDE+1); default 5.
  - out_valid is asserted exactly LAT cycles after the launching in_valid.
  - At the maximum rate (in_valid every cycle), outputs appear every second cycle.
- Scaling: add 2^(COEF_W-2), arithmetic shift right by COEF_W-1, then limit to DATA_W.
- Output hold: out_i/out_q hold their last value while out_valid=0.
- sync_clr=1 for a cycle:
  - zero the delay lines;
  - phase reset to 0;
  - in-flight valids killed, so no out_valid on the following LAT cycles from pre-clear samples.
  - out_i/out_q keep their last value.
  - If in_valid and sync_clr are asserted together, clear wins and the sample is discarded.
- I and Q share phase and valid, and always emerge on the same cycle.

Optional Feature:
- ADRV9009_HB_DEC_SAT_EN
  - Defined: limiting saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Undefined: limiting truncates MSBs (two's-complement wrap). Saves the compare logic.

Decomposition:
- Package adrv9009_rx_pkg:
  - clog2 function;
  - default HB coefficient constants;
  - LAT/ACC_W derivation functions;
  - sample typedef sized by DATA_W.
- Sub-module adrv9009_hb_mac: per-channel delay line, pre-add, multiply, tree and round/limit datapath. Instantiated twice (I, Q).
- Phase and valid pipeline are shared in the top level.

Test Plan:
- DC: in_i=1000, in_q=-1000 every cycle for 40 cycles -> after settling, every out_valid gives out_i=1000, out_q=-1000. out_valid appears on alternate cycles.
- Impulse on phase 1: in_i=16384 on the 2nd accepted sample, zeros otherwise -> successive out_i = 288, -1232, 5040, 5040, -1232, 288, then 0. The first output comes exactly 5 cycles after that in_valid.
- Impulse on phase 0: in_i=16384 on the 1st sample -> single out_i=8192 (centre only), all others 0.
- Overflow: window holds 32767 where the coefficient is positive and -32768 where it is negative -> out_i=32767 with ADRV9009_HB_DEC_SAT_EN, out_i=-22913 without.
- Gapped input: in_valid every 3rd cycle with the DC=1000 pattern -> same output values; one out_valid per two accepted samples, each LAT cycles after its launching sample.
- Flush and reset:
  - sync_clr together with in_valid mid-stream -> no out_valid for pre-clear data; the next sample is phase 0.
  - reset_n pulsed low asynchronously mid-burst -> outputs are 0 immediately and restart cleanly.

Source files
------------

// File: rtl/adrv9009_rx_pkg.sv
// Shared constants, types and helpers for the ADRV9009 Rx half-band path.
// Default coefficient set is the 11-tap decimating half-band (DC gain 1.0).
package adrv9009_rx_pkg;

   localparam int HB_DATA_W = 16;
   localparam int HB_COEF_W = 16;
   localparam int HB_NTAPS  = 11;

   localparam logic [3*HB_COEF_W-1:0] HB_SIDE_COEFS =
      {16'sd576, -16'sd2464, 16'sd10080};
   localparam logic signed [HB_COEF_W-1:0] HB_CENTER_COEF = 16'sd16384;

   typedef logic signed [HB_DATA_W-1:0] sample_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   function automatic int hb_lat(input int nside);
      return 3 + clog2(nside + 1);
   endfunction

   function automatic int hb_acc_w(input int dw, input int cw, input int nside);
      return dw + cw + 1 + clog2(nside + 1);
   endfunction

endpackage

// File: rtl/adrv9009_hb_mac.sv
// Per-channel half-band datapath: delay line, pre-add, multiply, adder tree,
// round/limit. Saturating limit when ADRV9009_HB_DEC_SAT_EN is defined.
module adrv9009_hb_mac
   import adrv9009_rx_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 11,
   parameter logic [((NTAPS+1)/4)*COEF_W-1:0] SIDE_COEFS = HB_SIDE_COEFS,
   parameter logic signed [COEF_W-1:0] CENTER_COEF = HB_CENTER_COEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              shift,
   input  logic              clr,
   input  logic              ld,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int NSIDE = (NTAPS + 1) / 4;
   localparam int C     = (NTAPS - 1) / 2;
   localparam int PW    = DATA_W + 1;
   localparam int MW    = DATA_W + COEF_W + 1;
   localparam int ACC_W = hb_acc_w(DATA_W, COEF_W, NSIDE);
   localparam int S     = clog2(NSIDE + 1);
   localparam int P     = 1 << S;

   localparam logic signed [ACC_W-1:0] HALF =
      {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};

   logic signed [DATA_W-1:0] dl   [NTAPS-1];
   logic signed [DATA_W-1:0] win  [NTAPS];
   logic signed [PW-1:0]     pa   [NSIDE];
   logic signed [DATA_W-1:0] pc;
   logic signed [MW-1:0]     pm   [NSIDE];
   logic signed [MW-2:0]     pcm;
   logic signed [ACC_W-1:0]  term [P];
   logic signed [ACC_W-1:0]  node [P-1];
   logic signed [ACC_W-1:0]  rnd;
   logic signed [DATA_W-1:0] lim;

   // The live input is tap 0, so the launching sample is in its own window.
   always_comb begin
      win[0] = din;
      for (int k = 1; k < NTAPS; k++) win[k] = dl[k-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NTAPS-1; k++) dl[k] <= '0;
      end else if (clr) begin
         for (int k = 0; k < NTAPS-1; k++) dl[k] <= '0;
      end else if (shift) begin
         dl[0] <= din;
         for (int k = 1; k < NTAPS-1; k++) dl[k] <= dl[k-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < NSIDE; j++) begin
            pa[j] <= '0;
            pm[j] <= '0;
         end
         pc  <= '0;
         pcm <= '0;
      end else begin
         for (int j = 0; j < NSIDE; j++) begin
            pa[j] <= $signed({win[C-2*j-1][DATA_W-1], win[C-2*j-1]})
                   + $signed({win[C+2*j+1][DATA_W-1], win[C+2*j+1]});
            pm[j] <= MW'(pa[j])
                   * MW'($signed(SIDE_COEFS[j*COEF_W +: COEF_W]));
         end
         pc  <= win[C];
         pcm <= (MW-1)'(pc) * (MW-1)'(CENTER_COEF);
      end
   end

   always_comb begin
      term = '{default: '0};
      for (int j = 0; j < NSIDE; j++) term[j] = ACC_W'(pm[j]);
      term[NSIDE] = ACC_W'(pcm);
   end

   // Level s of the tree lives at node[P-(P>>(s-1)) +: P>>s].
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int n = 0; n < P-1; n++) node[n] <= '0;
      end else begin
         for (int k = 0; k < P/2; k++)
            node[k] <= term[2*k] + term[2*k+1];
         for (int s = 2; s <= S; s++)
            for (int k = 0; k < (P >> s); k++)
               node[P-(P>>(s-1))+k] <= node[P-(P>>(s-2))+2*k]
                                     + node[P-(P>>(s-2))+2*k+1];
      end
   end

   assign rnd = node[P-2] + HALF;

`ifdef ADRV9009_HB_DEC_SAT_EN
   localparam logic signed [ACC_W-1:0] MAXV =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [ACC_W-1:0] shr;

   always_comb begin
      shr = rnd >>> (COEF_W - 1);
      lim = shr[DATA_W-1:0];
      if (shr > MAXV)      lim = MAXV[DATA_W-1:0];
      else if (shr < MINV) lim = MINV[DATA_W-1:0];
   end
`else
   always_comb begin
      lim = DATA_W'(rnd >>> (COEF_W - 1));
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  dout <= '0;
      else if (ld)   dout <= lim;
   end

endmodule

// File: rtl/adrv9009_hb_dec.sv
// Half-band decimate-by-2 for one I/Q pair; shared phase and valid pipeline.
// Define ADRV9009_HB_DEC_SAT_EN for saturating output instead of wrap.
module adrv9009_hb_dec
   import adrv9009_rx_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 11,
   parameter logic [((NTAPS+1)/4)*COEF_W-1:0] SIDE_COEFS = HB_SIDE_COEFS,
   parameter logic signed [COEF_W-1:0] CENTER_COEF = HB_CENTER_COEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sync_clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_i,
   input  logic [DATA_W-1:0] in_q,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_i,
   output logic [DATA_W-1:0] out_q
);

   localparam int NSIDE = (NTAPS + 1) / 4;
   localparam int LAT   = hb_lat(NSIDE);

   if (NTAPS < 7 || ((NTAPS + 1) % 4) != 0) begin : g_bad_ntaps
      $error("adrv9009_hb_dec: NTAPS must be 4M-1 with M>=2");
   end

   logic           phase;
   logic [LAT-1:0] vld;
   logic           accept;
   logic           launch;
   logic           ld;

   assign accept    = in_valid & ~sync_clr;
   assign launch    = accept & phase;
   assign ld        = vld[LAT-2] & ~sync_clr;
   assign out_valid = vld[LAT-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase <= 1'b0;
         vld   <= '0;
      end else if (sync_clr) begin
         phase <= 1'b0;
         vld   <= '0;
      end else begin
         if (accept) phase <= ~phase;
         vld <= {vld[LAT-2:0], launch};
      end
   end

   adrv9009_hb_mac #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS),
      .SIDE_COEFS(SIDE_COEFS), .CENTER_COEF(CENTER_COEF)
   ) u_mac_i (
      .clk(clk), .reset_n(reset_n), .shift(accept), .clr(sync_clr),
      .ld(ld), .din(in_i), .dout(out_i)
   );

   adrv9009_hb_mac #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS),
      .SIDE_COEFS(SIDE_COEFS), .CENTER_COEF(CENTER_COEF)
   ) u_mac_q (
      .clk(clk), .reset_n(reset_n), .shift(accept), .clr(sync_clr),
      .ld(ld), .din(in_q), .dout(out_q)
   );

endmodule
